// File: rtl/text_pkg.sv
// Shared constants and types for the character-cell text renderer.
package text_pkg;

  localparam int CELL_SIZE             = 16;
  localparam int GLYPH_SIZE            = 8;
  localparam int SCALE                 = 2;
  localparam int CELL_SHIFT            = $clog2(CELL_SIZE);
  localparam int DEFAULT_SCREEN_WIDTH  = 76;
  localparam int DEFAULT_SCREEN_HEIGHT = 44;

  typedef logic [23:0] rgb_t;

endpackage

// File: rtl/text_grid_renderer_pipe_delay.sv
// pipe_delay: fixed-depth shift register that keeps side-band data aligned with the render pipeline.
module pipe_delay #(
  parameter int DEPTH = 1,
  parameter int WIDTH = 1
) (
  input  logic             pixel_clk_in,
  input  logic             rst_in,
  input  logic [WIDTH-1:0] data_in,
  output logic [WIDTH-1:0] data_out
);

  logic [WIDTH-1:0] stage_r [DEPTH];

  // Shift chain, cleared asynchronously.
  always_ff @(posedge pixel_clk_in or posedge rst_in) begin
    if (rst_in) begin
      for (int i = 0; i < DEPTH; i++) stage_r[i] <= '0;
    end else begin
      stage_r[0] <= data_in;
      for (int i = 1; i < DEPTH; i++) stage_r[i] <= stage_r[i-1];
    end
  end

  assign data_out = stage_r[DEPTH-1];

endmodule

// File: rtl/text_grid_renderer.sv
// text_grid_renderer: 7-cycle pipeline turning pixel coordinates into RGB via text-grid RAM and font ROM.
// Define CURSOR_BLINK_EN to build the blinking inverted-cell cursor.
module text_grid_renderer
  import text_pkg::*;
#(
  parameter int   SCREEN_WIDTH  = DEFAULT_SCREEN_WIDTH,
  parameter int   SCREEN_HEIGHT = DEFAULT_SCREEN_HEIGHT,
  parameter int   X_OFFSET      = 32,
  parameter int   Y_OFFSET      = 8,
  parameter rgb_t FG_COLOR      = 24'hFFFFFF,
  parameter rgb_t BG_COLOR      = 24'h000000,
  parameter int   BLINK_FRAMES  = 30
) (
  input  logic                                         pixel_clk_in,
  input  logic                                         rst_in,
  input  logic [10:0]                                  hcount_in,
  input  logic [9:0]                                   vcount_in,
  input  logic                                         active_draw_in,
  input  logic                                         hsync_in,
  input  logic                                         vsync_in,
  output logic [$clog2(SCREEN_WIDTH*SCREEN_HEIGHT)-1:0] tg_addr_out,
  input  logic [7:0]                                   tg_data_in,
  output logic [10:0]                                  font_addr_out,
  input  logic [7:0]                                   font_data_in,
  input  logic [$clog2(SCREEN_WIDTH)-1:0]              cursor_x_in,
  input  logic [$clog2(SCREEN_HEIGHT)-1:0]             cursor_y_in,
  output rgb_t                                         pixel_out,
  output logic                                         hsync_out,
  output logic                                         vsync_out,
  output logic                                         active_draw_out
);

  localparam int ADDR_W = $clog2(SCREEN_WIDTH*SCREEN_HEIGHT);
  localparam int CTRL_W = 8;

  int                x_rel_s, y_rel_s, col_s, row_s;
  logic              in_region_s, cursor_hit_s;
  logic [2:0]        x_sub_s, y_sub_s, y_sub_d3_s, x_sub_d6_s;
  logic [ADDR_W-1:0] tg_addr_s;
  logic [CTRL_W-1:0] ctrl_d6_s;
  logic              hsync_d6_s, vsync_d6_s, active_d6_s, in_region_d6_s, cursor_hit_d6_s;
  logic              blank_d3_s, glyph_bit_s, fg_sel_s;
  rgb_t              pixel_next_s;

`ifdef CURSOR_BLINK_EN
  localparam int BLINK_W = $clog2(BLINK_FRAMES + 1);
  logic [BLINK_W-1:0] blink_cnt_r;
  logic               vsync_prev_r, phase_visible_r;

  // Frame counter on vsync rising edges; flips cursor phase every BLINK_FRAMES frames.
  always_ff @(posedge pixel_clk_in or posedge rst_in) begin
    if (rst_in) begin
      blink_cnt_r     <= '0;
      vsync_prev_r    <= 1'b0;
      phase_visible_r <= 1'b1;
    end else begin
      vsync_prev_r <= vsync_in;
      if (vsync_in && !vsync_prev_r) begin
        if (blink_cnt_r == BLINK_W'(BLINK_FRAMES - 1)) begin
          blink_cnt_r     <= '0;
          phase_visible_r <= ~phase_visible_r;
        end else begin
          blink_cnt_r <= blink_cnt_r + BLINK_W'(1);
        end
      end
    end
  end
`else
  logic unused_cursor_s;
  assign unused_cursor_s = ^{cursor_x_in, cursor_y_in, BLINK_FRAMES[0]};
`endif

  // Cell coordinates, region test and grid address for the incoming pixel.
  always_comb begin
    x_rel_s     = int'(hcount_in) - X_OFFSET;
    y_rel_s     = int'(vcount_in) - Y_OFFSET;
    col_s       = x_rel_s >>> CELL_SHIFT;
    row_s       = y_rel_s >>> CELL_SHIFT;
    x_sub_s     = x_rel_s[3:1];
    y_sub_s     = y_rel_s[3:1];
    in_region_s = (x_rel_s >= 0) && (x_rel_s < CELL_SIZE * SCREEN_WIDTH) &&
                  (y_rel_s >= 0) && (y_rel_s < CELL_SIZE * SCREEN_HEIGHT);
    if (in_region_s) begin
      tg_addr_s = ADDR_W'(row_s * SCREEN_WIDTH + col_s);
    end else begin
      tg_addr_s = '0;
    end
`ifdef CURSOR_BLINK_EN
    cursor_hit_s = in_region_s && phase_visible_r &&
                   (col_s == int'(cursor_x_in)) && (row_s == int'(cursor_y_in));
`else
    cursor_hit_s = 1'b0;
`endif
  end

  pipe_delay #(.DEPTH(6), .WIDTH(CTRL_W)) u_ctrl_dly (
    .pixel_clk_in (pixel_clk_in),
    .rst_in       (rst_in),
    .data_in      ({hsync_in, vsync_in, active_draw_in, in_region_s, cursor_hit_s, x_sub_s}),
    .data_out     (ctrl_d6_s)
  );

  pipe_delay #(.DEPTH(3), .WIDTH(3)) u_yrow_dly (
    .pixel_clk_in (pixel_clk_in),
    .rst_in       (rst_in),
    .data_in      (y_sub_s),
    .data_out     (y_sub_d3_s)
  );

  // Code 0 must render blank, so its flag follows the font lookup to the output stage.
  pipe_delay #(.DEPTH(3), .WIDTH(1)) u_blank_dly (
    .pixel_clk_in (pixel_clk_in),
    .rst_in       (rst_in),
    .data_in      (tg_data_in == 8'h00),
    .data_out     (blank_d3_s)
  );

  assign {hsync_d6_s, vsync_d6_s, active_d6_s, in_region_d6_s, cursor_hit_d6_s, x_sub_d6_s} = ctrl_d6_s;

  // Glyph bit selection and colour choice for the output stage.
  always_comb begin
    glyph_bit_s = font_data_in[3'd7 - x_sub_d6_s];
    fg_sel_s    = (glyph_bit_s & ~blank_d3_s) ^ cursor_hit_d6_s;
    if (!active_d6_s) begin
      pixel_next_s = 24'h000000;
    end else if (!in_region_d6_s) begin
      pixel_next_s = BG_COLOR;
    end else if (fg_sel_s) begin
      pixel_next_s = FG_COLOR;
    end else begin
      pixel_next_s = BG_COLOR;
    end
  end

  // Memory address stages (cycles 1 and 4) and the registered output stage (cycle 7).
  always_ff @(posedge pixel_clk_in or posedge rst_in) begin
    if (rst_in) begin
      tg_addr_out     <= '0;
      font_addr_out   <= 11'd0;
      pixel_out       <= 24'h000000;
      hsync_out       <= 1'b0;
      vsync_out       <= 1'b0;
      active_draw_out <= 1'b0;
    end else begin
      tg_addr_out     <= tg_addr_s;
      font_addr_out   <= {tg_data_in, y_sub_d3_s};
      pixel_out       <= pixel_next_s;
      hsync_out       <= hsync_d6_s;
      vsync_out       <= vsync_d6_s;
      active_draw_out <= active_d6_s;
    end
  end

endmodule

// File: doc/text_grid_renderer.md
TEXT_GRID_RENDERER -- requirements
Module: text_grid_renderer

Interface
REQ-001 Parameters, one per line: name, default, meaning:
- SCREEN_WIDTH, 76, character columns
- SCREEN_HEIGHT, 44, character rows
- X_OFFSET, 32, left margin in pixels
- Y_OFFSET, 8, top margin in pixels
- FG_COLOR, 24'hFFFFFF, glyph colour
- BG_COLOR, 24'h000000, background colour
- BLINK_FRAMES, 30, frames per cursor phase
REQ-002 Ports, one per line: name, direction, width, meaning:
- pixel_clk_in, in, 1, sole clock
- rst_in, in, 1, reset; asynchronous, active-high
- hcount_in, in, 11, pixel x
- vcount_in, in, 10, pixel y
- active_draw_in, in, 1, visible-area flag
- hsync_in, in, 1, horizontal sync
- vsync_in, in, 1, vertical sync
- tg_addr_out, out, $clog2(SCREEN_WIDTH*SCREEN_HEIGHT), text-grid read address
- tg_data_in, in, 8, character code; valid 2 cycles after tg_addr_out
- font_addr_out, out, 11, font ROM address, {char[7:0], row[2:0]}
- font_data_in, in, 8, glyph row; valid 2 cycles after font_addr_out
- cursor_x_in, in, $clog2(SCREEN_WIDTH), cursor column
- cursor_y_in, in, $clog2(SCREEN_HEIGHT), cursor row
- pixel_out, out, 24, RGB colour
- hsync_out, out, 1, delayed hsync
- vsync_out, out, 1, delayed vsync
- active_draw_out, out, 1, delayed active flag

Function
REQ-003 Cells SHALL be 16x16 pixels: 8x8 glyph scaled 2x; text region x in [X_OFFSET, X_OFFSET+16*SCREEN_WIDTH), y in [Y_OFFSET, Y_OFFSET+16*SCREEN_HEIGHT).
REQ-004 Cycle 1: register tg_addr_out = row*SCREEN_WIDTH+col, where col=(hcount_in-X_OFFSET)>>4 and row=(vcount_in-Y_OFFSET)>>4; outside the region, tg_addr_out = 0.
REQ-005 Cycle 3: sample tg_data_in. Cycle 4: register font_addr_out = {char, ((vcount-Y_OFFSET)>>1)[2:0]}. Cycle 6: sample font_data_in. Cycle 7: register pixel_out.
REQ-006 Glyph bit SHALL be font_data[7 - ((hcount-X_OFFSET)>>1)[2:0]]; MSB is leftmost.
REQ-007 pixel_out SHALL be FG_COLOR when bit=1, BG_COLOR when bit=0 or outside the text region, and 0 when delayed active_draw is 0.
REQ-008 Character code 0 SHALL render as all-background regardless of font_data_in.
REQ-009 hsync_out, vsync_out, active_draw_out, region flag and pixel sub-coordinates SHALL be delayed so they align with pixel_out; total latency is exactly 7 cycles.
REQ-010 Pipeline SHALL accept a new pixel every cycle with no stalls; the hcount wrap from the last column to 0 needs no special handling.

Reset
REQ-011 On rst_in=1 (asynchronous), these SHALL clear to 0 immediately: all pipeline registers, pixel_out, tg_addr_out, font_addr_out, all sync outputs and the blink counter; cursor phase SHALL be set to visible.
REQ-012 After rst_in deasserts mid-frame, outputs SHALL be valid from the 7th clock on; earlier outputs SHALL be 0.

Configuration
REQ-013 Macro CURSOR_BLINK_EN present: the blink counter SHALL count vsync_in rising edges and toggle the phase every BLINK_FRAMES frames. While the phase is visible, the cell at (cursor_x_in, cursor_y_in), sampled at cycle 1, SHALL render with FG/BG swapped.
REQ-014 Macro CURSOR_BLINK_EN absent: cursor ports SHALL exist but be ignored, no blink logic SHALL be synthesised, and no cell is inverted.

Structure
REQ-015 Package text_pkg SHALL hold the cell size (16), glyph size (8), scale (2), the rgb_t typedef and the default screen dimensions.
REQ-016 Delay alignment SHALL use one sub-module, pipe_delay (parameters DEPTH, WIDTH), with asynchronous reset.

Verification
REQ-017 Bench SHALL use behavioural 2-cycle BRAM and ROM models. Directed scenarios, stimulus -> required response:
- Grid cell (0,0) = 8'h41, font row0 = 8'h80; drive hcount=32, vcount=8 -> tg_addr_out=0 at cycle 1; font_addr_out=11'h208 at cycle 4; pixel_out=FFFFFF at cycle 7; hcount=34 -> BG.
- hcount=1248 or vcount=7 -> pixel_out=BG_COLOR; active_draw_in=0 -> pixel_out=0; sync outputs equal inputs delayed 7 cycles.
- Cell (75,43) = 8'h00, ROM returns FF -> all 256 pixels BG; tg_addr_out=3343.
- Toggle hsync_in/vsync_in at a known cycle -> outputs toggle exactly 7 cycles later.
- CURSOR_BLINK_EN, cursor (2,1): frames 0-29 cell inverted, frames 30-59 normal, frame 60 inverted again.
- Assert rst_in mid-line between clock edges -> all outputs 0 before the next edge; valid pixels resume 7 cycles after release.
